imem_fetch: RTL and testbench

Parametrised, handshaked instruction memory for the CPU fetch stage. It accepts one fetch request at a time on a valid/ready interface and reads a synchronous word array after a configurable number of cycles. Each request returns exactly one response, holding either the instruction word or a single one-shot exception (misaligned or access fault) with its trap value. A flush input cancels an in-flight fetch on redirects and traps.

---
 rtl/cpu_pkg.sv | 14 +
 rtl/imem_array.sv | 20 ++
 rtl/imem_fetch.sv | 164 ++++++++++++++++
 tb/tb_imem_fetch.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: exception causes, the canonical NOP and the fetch FSM states.
package cpu_pkg;

    localparam logic [3:0]  EXC_INSTR_MISALIGNED   = 4'd0;
    localparam logic [3:0]  EXC_INSTR_ACCESS_FAULT = 4'd1;
    localparam logic [31:0] INSTR_NOP              = 32'h00000013;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } fetch_state_t;

endpackage

// File: rtl/imem_array.sv
// Single-port synchronous-read instruction ROM.
module imem_array #(
  parameter int unsigned DEPTH_WORDS = 2048,
  parameter int unsigned IDX_W       = $clog2(DEPTH_WORDS),
  parameter string       INIT_FILE   = ""
) (
  input  logic             clk,
  input  logic             rd_en,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [31:0]      rd_data
);

  logic [31:0] mem [DEPTH_WORDS];

  // Output register only moves on a read, so it holds the word for the whole response.
  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_idx];
  end

endmodule

// File: rtl/imem_fetch.sv
// Fetch-stage instruction memory: one request in flight, fixed latency, one response
// carrying either the word or a one-shot misaligned/access-fault exception.
module imem_fetch
    import cpu_pkg::*;
#(
    parameter int unsigned     XLEN        = 64,
    parameter int unsigned     DEPTH_WORDS = 2048,
    parameter logic [XLEN-1:0] BASE_ADDR   = '0,
    parameter int unsigned     LATENCY     = 1,
    parameter string           INIT_FILE   = ""
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [XLEN-1:0] req_addr,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [31:0]     rsp_instr,
    output logic            rsp_exc_en,
    output logic [3:0]      rsp_exc_code,
    output logic [XLEN-1:0] rsp_exc_val
);

    localparam int unsigned     IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [XLEN-1:0] SPAN     = XLEN'(DEPTH_WORDS * 4);
    localparam logic [2:0]      CNT_INIT = 3'(LATENCY - 1);

    fetch_state_t    state, state_n;
    logic [2:0]      cnt, cnt_n;
    logic            accept, issue;

    logic [XLEN-1:0] addr_q;
    logic            exc_q;
    logic [3:0]      code_q;

    logic [XLEN-1:0] offset;
    logic            cls_mis, cls_fault, cls_exc;
    logic [3:0]      cls_code;

    logic [XLEN-1:0] sel_addr;
    logic            sel_exc;
    logic [3:0]      sel_code;

    logic [IDX_W-1:0] rd_idx;
    logic             rd_en;
    logic [31:0]      rd_data;

    logic             valid_q, exc_en_q;
    logic [3:0]       exc_code_q;
    logic [XLEN-1:0]  exc_val_q;

    // Offset form of the range check avoids overflow of BASE_ADDR + span at XLEN width.
    assign offset    = req_addr - BASE_ADDR;
    assign cls_mis   = |req_addr[1:0];
    assign cls_fault = (req_addr < BASE_ADDR) || (offset >= SPAN);
    assign cls_exc   = cls_mis || cls_fault;
    assign cls_code  = cls_mis ? EXC_INSTR_MISALIGNED : EXC_INSTR_ACCESS_FAULT;

    assign req_ready = (state == ST_IDLE) && !flush && !rst;
    assign accept    = req_valid && req_ready;

    // With LATENCY 1 the read issues on the acceptance edge, straight from the request.
    assign sel_addr = (state == ST_IDLE) ? req_addr : addr_q;
    assign sel_exc  = (state == ST_IDLE) ? cls_exc  : exc_q;
    assign sel_code = (state == ST_IDLE) ? cls_code : code_q;
    assign rd_idx   = IDX_W'((sel_addr - BASE_ADDR) >> 2);
    assign rd_en    = issue && !sel_exc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        issue   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (accept) begin
                    cnt_n = CNT_INIT;
                    if (LATENCY > 1) begin
                        state_n = ST_WAIT;
                    end else begin
                        state_n = ST_RESP;
                        issue   = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (flush) begin
                    state_n = ST_IDLE;
                    cnt_n   = '0;
                end else if (cnt <= 3'd1) begin
                    state_n = ST_RESP;
                    cnt_n   = '0;
                    issue   = 1'b1;
                end else begin
                    cnt_n = cnt - 3'd1;
                end
            end
            ST_RESP: begin
                if (flush || rsp_ready) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= '0;
            exc_q  <= 1'b0;
            code_q <= '0;
        end else if (accept) begin
            addr_q <= req_addr;
            exc_q  <= cls_exc;
            code_q <= cls_code;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= 1'b0;
            exc_en_q   <= 1'b0;
            exc_code_q <= '0;
            exc_val_q  <= '0;
        end else if (issue) begin
            valid_q    <= 1'b1;
            exc_en_q   <= sel_exc;
            exc_code_q <= sel_exc ? sel_code : '0;
            exc_val_q  <= sel_exc ? sel_addr : '0;
        end else if ((state == ST_RESP) && (flush || rsp_ready)) begin
            valid_q    <= 1'b0;
            exc_en_q   <= 1'b0;
            exc_code_q <= '0;
            exc_val_q  <= '0;
        end
    end

    imem_array #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .IDX_W      (IDX_W),
        .INIT_FILE  (INIT_FILE)
    ) u_array (
        .clk    (clk),
        .rd_en  (rd_en),
        .rd_idx (rd_idx),
        .rd_data(rd_data)
    );

    assign rsp_valid    = valid_q;
    assign rsp_exc_en   = exc_en_q;
    assign rsp_exc_code = exc_code_q;
    assign rsp_exc_val  = exc_val_q;
    assign rsp_instr    = (valid_q && !exc_en_q) ? rd_data : INSTR_NOP;

endmodule

// File: tb/tb_imem_fetch.sv
// Bench for imem_fetch: three instances (LATENCY 2, 1, 8) share stimulus and are
// checked against a queue/arithmetic reference built from the fetch rules.
module tb_imem_fetch;

    localparam int ND = 3;
    int LAT [ND] = '{2, 1, 8};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        req_valid = 1'b0;
    logic        rsp_ready = 1'b0;
    logic [63:0] req_addr = '0;

    logic        req_ready    [ND];
    logic        rsp_valid    [ND];
    logic [31:0] rsp_instr    [ND];
    logic        rsp_exc_en   [ND];
    logic [3:0]  rsp_exc_code [ND];
    logic [63:0] rsp_exc_val  [ND];

    int checks = 0;
    int errors = 0;

    logic [31:0] image [2048];

    typedef struct {
        logic        exc;
        logic [3:0]  code;
        logic [63:0] val;
        logic [31:0] instr;
    } exp_t;

    always #5 clk = ~clk;

    imem_fetch #(.XLEN(64), .DEPTH_WORDS(2048), .BASE_ADDR(64'h0), .LATENCY(2), .INIT_FILE("")) dut0 (
        .clk(clk), .rst(rst), .flush(flush), .req_valid(req_valid), .req_ready(req_ready[0]),
        .req_addr(req_addr), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready), .rsp_instr(rsp_instr[0]),
        .rsp_exc_en(rsp_exc_en[0]), .rsp_exc_code(rsp_exc_code[0]), .rsp_exc_val(rsp_exc_val[0]));

    imem_fetch #(.XLEN(64), .DEPTH_WORDS(2048), .BASE_ADDR(64'h0), .LATENCY(1), .INIT_FILE("")) dut1 (
        .clk(clk), .rst(rst), .flush(flush), .req_valid(req_valid), .req_ready(req_ready[1]),
        .req_addr(req_addr), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready), .rsp_instr(rsp_instr[1]),
        .rsp_exc_en(rsp_exc_en[1]), .rsp_exc_code(rsp_exc_code[1]), .rsp_exc_val(rsp_exc_val[1]));

    imem_fetch #(.XLEN(64), .DEPTH_WORDS(2048), .BASE_ADDR(64'h0), .LATENCY(8), .INIT_FILE("")) dut2 (
        .clk(clk), .rst(rst), .flush(flush), .req_valid(req_valid), .req_ready(req_ready[2]),
        .req_addr(req_addr), .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready), .rsp_instr(rsp_instr[2]),
        .rsp_exc_en(rsp_exc_en[2]), .rsp_exc_code(rsp_exc_code[2]), .rsp_exc_val(rsp_exc_val[2]));

    function automatic exp_t model(input logic [63:0] a);
        exp_t e;
        if (a[1:0] != 2'b00)      e = '{1'b1, 4'd0, a, 32'h00000013};
        else if (a >= 64'd8192)   e = '{1'b1, 4'd1, a, 32'h00000013};
        else                      e = '{1'b0, 4'd0, 64'd0, image[int'(a >> 2)]};
        return e;
    endfunction

    task automatic drain(input int n);
        @(posedge clk); #1;
        req_valid = 1'b0; flush = 1'b0; rsp_ready = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b1; req_addr = 64'h40; rsp_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++; if (req_ready[0] !== 1'b0) begin errors++; $display("FAIL reset_req_ready: got %b expected 0", req_ready[0]); end
            checks++; if (rsp_valid[0] !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid[0]); end
            checks++; if (rsp_instr[0] !== 32'h00000013) begin errors++; $display("FAIL reset_rsp_instr: got %h expected 00000013", rsp_instr[0]); end
            checks++; if (rsp_exc_en[0] !== 1'b0) begin errors++; $display("FAIL reset_exc_en: got %b expected 0", rsp_exc_en[0]); end
            checks++; if (rsp_exc_code[0] !== 4'd0) begin errors++; $display("FAIL reset_exc_code: got %h expected 0", rsp_exc_code[0]); end
            checks++; if (rsp_exc_val[0] !== 64'd0) begin errors++; $display("FAIL reset_exc_val: got %h expected 0", rsp_exc_val[0]); end
        end
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < ND; d++) begin
            checks++; if (req_ready[d] !== 1'b1) begin errors++; $display("FAIL release_req_ready dut%0d: got %b expected 1", d, req_ready[d]); end
        end
    endtask

    task automatic run_fetch(input logic [63:0] a, input string name);
        exp_t        e;
        int          first [ND];
        int          nval  [ND];
        logic [31:0] c_instr [ND];
        logic        c_exc   [ND];
        logic [3:0]  c_code  [ND];
        logic [63:0] c_val   [ND];
        e = model(a);
        for (int d = 0; d < ND; d++) begin first[d] = -1; nval[d] = 0; end
        @(posedge clk); #1;
        req_valid = 1'b1; req_addr = a; rsp_ready = 1'b1; flush = 1'b0;
        @(negedge clk);
        for (int d = 0; d < ND; d++) begin
            checks++; if (req_ready[d] !== 1'b1) begin errors++; $display("FAIL %s_ready dut%0d: got %b expected 1", name, d, req_ready[d]); end
        end
        for (int k = 0; k < 12; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
                req_valid = 1'b0;
                @(negedge clk);
            end
            for (int d = 0; d < ND; d++) begin
                if (rsp_valid[d] === 1'b1) begin
                    if (first[d] < 0) begin
                        first[d] = k; c_instr[d] = rsp_instr[d]; c_exc[d] = rsp_exc_en[d];
                        c_code[d] = rsp_exc_code[d]; c_val[d] = rsp_exc_val[d];
                    end
                    nval[d]++;
                end
            end
        end
        for (int d = 0; d < ND; d++) begin
            checks++; if (first[d] != LAT[d]) begin errors++; $display("FAIL %s_latency dut%0d: got %0d expected %0d", name, d, first[d], LAT[d]); end
            checks++; if (nval[d] != 1) begin errors++; $display("FAIL %s_count dut%0d: got %0d expected 1", name, d, nval[d]); end
            if (first[d] >= 0) begin
                checks++; if (c_instr[d] !== e.instr) begin errors++; $display("FAIL %s_instr dut%0d: got %h expected %h", name, d, c_instr[d], e.instr); end
                checks++; if (c_exc[d] !== e.exc) begin errors++; $display("FAIL %s_exc_en dut%0d: got %b expected %b", name, d, c_exc[d], e.exc); end
                checks++; if (c_code[d] !== e.code) begin errors++; $display("FAIL %s_exc_code dut%0d: got %h expected %h", name, d, c_code[d], e.code); end
                checks++; if (c_val[d] !== e.val) begin errors++; $display("FAIL %s_exc_val dut%0d: got %h expected %h", name, d, c_val[d], e.val); end
            end
        end
    endtask

    task automatic test_fetch();
        drain(2); run_fetch(64'h0, "fetch_word0");
    endtask

    task automatic test_access_fault();
        drain(2); run_fetch(64'h2000, "fault_first");
        drain(2); run_fetch(64'h2000, "fault_repeat");
    endtask

    task automatic test_misaligned();
        drain(2); run_fetch(64'h2002, "misaligned");
    endtask

    task automatic test_last_word();
        drain(2); run_fetch(64'h1FFC, "last_word");
    endtask

    task automatic test_random();
        logic [63:0] a;
        logic [31:0] hi, lo;
        for (int i = 0; i < 12; i++) begin
            hi = $urandom; lo = $urandom;
            case ($urandom_range(0, 3))
                0, 1: a = 64'($urandom_range(0, 2047)) << 2;
                2: begin a = {hi, lo}; a[1:0] = 2'b00; if (a < 64'd8192) a = a + 64'd8192; end
                default: a = {hi, lo};
            endcase
            drain(1);
            run_fetch(a, "random");
        end
    endtask

    task automatic test_backpressure();
        exp_t        e;
        logic [63:0] a;
        logic        seen;
        int          nval;
        logic [100:0] snap, cur;
        a = 64'($urandom_range(0, 2047)) << 2;
        e = model(a);
        drain(2);
        rsp_ready = 1'b0; req_valid = 1'b1; req_addr = a;
        @(posedge clk); #1;
        req_valid = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 12 && !seen; k++) begin
            @(negedge clk);
            if (rsp_valid[0] === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++; $display("FAIL bp_valid_timeout: got no rsp_valid expected rsp_valid within 12 cycles");
        end else begin
            snap = {rsp_valid[0], rsp_instr[0], rsp_exc_en[0], rsp_exc_code[0], rsp_exc_val[0]};
            checks++; if (rsp_instr[0] !== e.instr || rsp_exc_en[0] !== e.exc) begin
                errors++; $display("FAIL bp_data: got %h/%b expected %h/%b", rsp_instr[0], rsp_exc_en[0], e.instr, e.exc); end
            for (int c = 0; c < 5; c++) begin
                @(negedge clk);
                cur = {rsp_valid[0], rsp_instr[0], rsp_exc_en[0], rsp_exc_code[0], rsp_exc_val[0]};
                checks++; if (cur !== snap) begin errors++; $display("FAIL bp_stable: got %h expected %h", cur, snap); end
                checks++; if (req_ready[0] !== 1'b0) begin errors++; $display("FAIL bp_req_ready: got %b expected 0", req_ready[0]); end
            end
            rsp_ready = 1'b1;
            nval = 0;
            for (int k = 0; k < 10; k++) begin
                if (k > 0) @(negedge clk);
                if (rsp_valid[0] === 1'b1) nval++;
            end
            checks++; if (nval != 1) begin errors++; $display("FAIL bp_delivered: got %0d expected 1", nval); end
        end
        drain(12);
    endtask

    task automatic test_flush();
        int nval;
        drain(2);
        req_valid = 1'b1; req_addr = 64'h100; rsp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        checks++; if (rsp_valid[0] !== 1'b0) begin errors++; $display("FAIL flush_wait_valid: got %b expected 0", rsp_valid[0]); end
        checks++; if (req_ready[0] !== 1'b1) begin errors++; $display("FAIL flush_wait_ready: got %b expected 1", req_ready[0]); end
        nval = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            for (int d = 0; d < ND; d++) if (rsp_valid[d] === 1'b1) nval++;
        end
        checks++; if (nval != 0) begin errors++; $display("FAIL flush_suppressed: got %0d responses expected 0", nval); end
    endtask

    task automatic test_flush_idle();
        int nval;
        drain(2);
        flush = 1'b1; req_valid = 1'b1; req_addr = 64'h8;
        @(negedge clk);
        checks++; if (req_ready[0] !== 1'b0) begin errors++; $display("FAIL flush_idle_ready: got %b expected 0", req_ready[0]); end
        @(posedge clk); #1;
        flush = 1'b0; req_valid = 1'b0;
        nval = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (rsp_valid[0] === 1'b1) nval++;
        end
        checks++; if (nval != 0) begin errors++; $display("FAIL flush_idle_accept: got %0d responses expected 0", nval); end
    endtask

    task automatic test_reset_resp();
        int nval;
        drain(2);
        req_valid = 1'b1; req_addr = 64'h10; rsp_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++; if (rsp_valid[0] !== 1'b1) begin errors++; $display("FAIL rst_resp_pre: got %b expected 1", rsp_valid[0]); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (rsp_valid[0] !== 1'b0) begin errors++; $display("FAIL rst_resp_valid: got %b expected 0", rsp_valid[0]); end
        checks++; if (rsp_instr[0] !== 32'h00000013) begin errors++; $display("FAIL rst_resp_instr: got %h expected 00000013", rsp_instr[0]); end
        rst = 1'b0; rsp_ready = 1'b1;
        @(negedge clk);
        checks++; if (req_ready[0] !== 1'b1) begin errors++; $display("FAIL rst_resp_ready: got %b expected 1", req_ready[0]); end
        nval = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (rsp_valid[0] === 1'b1) nval++;
        end
        checks++; if (nval != 0) begin errors++; $display("FAIL rst_resp_suppressed: got %0d responses expected 0", nval); end
    endtask

    task automatic test_back_to_back();
        exp_t q [$];
        int   acc_cyc [$];
        exp_t e;
        int   acc, ac;
        drain(2);
        req_valid = 1'b1; rsp_ready = 1'b1;
        acc = 0;
        for (int c = 0; c < 30; c++) begin
            if (c > 0) begin @(posedge clk); #1; end
            req_addr = 64'($urandom_range(0, 2047)) << 2;
            if ($urandom_range(0, 5) == 0) req_addr = req_addr + 64'd8192;
            @(negedge clk);
            if (rsp_valid[0] === 1'b1) begin
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL b2b_unexpected: got response at cycle %0d expected none", c);
                end else begin
                    e = q.pop_front(); ac = acc_cyc.pop_front();
                    if (rsp_instr[0] !== e.instr || rsp_exc_en[0] !== e.exc || rsp_exc_val[0] !== e.val || (c - ac) != 2) begin
                        errors++; $display("FAIL b2b_rsp: got %h/%b/%h lat %0d expected %h/%b/%h lat 2",
                                           rsp_instr[0], rsp_exc_en[0], rsp_exc_val[0], c - ac, e.instr, e.exc, e.val);
                    end
                end
            end
            if (req_ready[0] === 1'b1) begin
                q.push_back(model(req_addr)); acc_cyc.push_back(c); acc++;
            end
        end
        req_valid = 1'b0;
        checks++; if (acc != 10) begin errors++; $display("FAIL b2b_throughput: got %0d accepts expected 10", acc); end
        checks++; if (q.size() != 0) begin errors++; $display("FAIL b2b_outstanding: got %0d pending expected 0", q.size()); end
        drain(12);
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) begin
            image[i] = $urandom;
            dut0.u_array.mem[i] = image[i];
            dut1.u_array.mem[i] = image[i];
            dut2.u_array.mem[i] = image[i];
        end
        test_reset();
        test_fetch();
        test_access_fault();
        test_misaligned();
        test_last_word();
        test_random();
        test_backpressure();
        test_flush();
        test_flush_idle();
        test_reset_resp();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
